// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Optional stop-on-first-fail build: define TTS_STOP_ON_FAIL_EN.
package tts_pkg;

  // Sweeper FSM state encoding.
  typedef logic [1:0] tts_state_t;

  localparam tts_state_t ST_IDLE   = 2'd0;
  localparam tts_state_t ST_HOLD   = 2'd1;
  localparam tts_state_t ST_FINISH = 2'd2;

  // Default input count and its vector count.
  localparam int N_IN_DEF = 4;
  localparam int NVEC     = 2 ** N_IN_DEF;

  // Vector count for a given number of inputs.
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

  // Width of the settle-window counter.
  function automatic int cnt_w(input int hold);
    return $clog2(hold) + 1;
  endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Loadable down-counter timing the settle window of each vector.
// Raises o_zero once the loaded count has been consumed.
module tts_hold_timer
  import tts_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors, captures Y, compares to a mask.
// Optional: TTS_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2**N_IN-1:0]    expected,
  output logic [N_IN-1:0]       vec,
  input  logic                  y_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2**N_IN-1:0]    captured,
  output logic [N_IN-1:0]       fail_index,
  output logic [N_IN:0]         mismatch_count
);

  localparam int NV = nvec(N_IN);
  localparam int CW = cnt_w(HOLD_CYCLES);

  localparam logic [CW-1:0] LOAD_VAL =
    CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VLAST =
    N_IN'(NV - 1);

  tts_state_t       r_state;
  logic [N_IN-1:0]  r_vec;
  logic [NV-1:0]    r_exp;
  logic [NV-1:0]    r_cap;
  logic [N_IN-1:0]  r_fidx;
  logic [N_IN:0]    r_mcnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_zero;
  logic             w_accept;
  logic             w_sample;
  logic             w_mis;
  logic             w_last;
  logic             w_stop;
  logic             w_end;
  logic             w_load;
  logic             w_dec;
  logic [N_IN:0]    w_mcnt_nx;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_sample = (r_state == ST_HOLD) && w_zero;
  assign w_mis    = (y_in != r_exp[r_vec]);
  assign w_last   = (r_vec == VLAST);

`ifdef TTS_STOP_ON_FAIL_EN
  assign w_stop   = w_mis;
`else
  assign w_stop   = 1'b0;
`endif

  assign w_end    = w_sample && (w_last || w_stop);
  assign w_load   = w_accept || (w_sample && !w_end);
  assign w_dec    = (r_state == ST_HOLD) && !w_zero;

  assign w_mcnt_nx = r_mcnt + (N_IN+1)'(w_mis);

  tts_hold_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_en       (w_dec),
    .o_zero     (w_zero)
  );

  // Sequencing: state, vector stepping, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_HOLD;
            r_vec   <= '0;
            r_exp   <= expected;
            r_busy  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_sample) begin
            if (w_end) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec   <= r_vec + 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result capture: table bits, mismatch tally, verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap  <= '0;
      r_fidx <= '0;
      r_mcnt <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_cap  <= '0;
      r_fidx <= '0;
      r_mcnt <= '0;
      r_pass <= 1'b0;
    end else if (w_sample) begin
      r_cap[r_vec] <= y_in;
      if (w_mis) begin
        r_mcnt <= w_mcnt_nx;
        if (r_mcnt == '0) begin
          r_fidx <= r_vec;
        end
      end
      if (w_end) begin
        r_pass <= (w_mcnt_nx == '0);
      end
    end
  end

  assign vec            = r_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign captured       = r_cap;
  assign fail_index     = r_fidx;
  assign mismatch_count = r_mcnt;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default build plus a
// minimum-size instance (N_IN=3, HOLD_CYCLES=1).
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        y_in;
  logic        busy, done, pass;
  logic [15:0] captured;
  logic [3:0]  fail_index;
  logic [4:0]  mismatch_count;

  logic        s3;
  logic [7:0]  e3;
  logic [2:0]  v3;
  logic        y3;
  logic        b3, d3, p3;
  logic [7:0]  c3;
  logic [2:0]  fi3;
  logic [3:0]  mc3;

  int mode;
  int errs = 0;
  int checks = 0;

  function automatic logic f4(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (a & b) | (a & c & d) | (a & ~c & ~d);
  endfunction

  always_comb y_in = (mode == 0) ? f4(vec) : 1'b0;
  always_comb y3 = v3[1] | (~v3[2] & ~v3[0]);

  truth_table_sweeper #(
    .N_IN(4), .HOLD_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .expected(expected), .vec(vec), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass),
    .captured(captured), .fail_index(fail_index),
    .mismatch_count(mismatch_count)
  );

  truth_table_sweeper #(
    .N_IN(3), .HOLD_CYCLES(1)
  ) dut3 (
    .clk(clk), .reset(reset), .start(s3),
    .expected(e3), .vec(v3), .y_in(y3),
    .busy(b3), .done(d3), .pass(p3),
    .captured(c3), .fail_index(fi3),
    .mismatch_count(mc3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Accept a sweep, then count cycles until done (bounded).
  task automatic sweep(input int md, input logic [15:0] ex,
                       input bit hold_start, output int cyc);
    @(negedge clk);
    mode = md;
    expected = ex;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 200);
  endtask

  typedef struct {
    string       nm;
    int          md;
    logic [15:0] ex;
    logic [15:0] cap;
    logic        ps;
    logic [4:0]  mc;
    logic [3:0]  fi;
    int          cyc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cyc;
    int n;
    int dn;
    start = 1'b0;
    expected = '0;
    mode = 0;
    s3 = 1'b0;
    e3 = '0;
    reset = 1'b1;

    tbl[0] = '{"golden", 0, 16'hF900, 16'hF900,
               1'b1, 5'd0, 4'd0, 33};
    tbl[1] = '{"stuck0", 1, 16'hF900, 16'h0000,
               1'b0, 5'd6, 4'd8, 33};
    tbl[2] = '{"bit0", 0, 16'hF901, 16'hF900,
               1'b0, 5'd1, 4'd0, 33};
    tbl[3] = '{"lastvec", 0, 16'h7900, 16'hF900,
               1'b0, 5'd1, 4'd15, 33};
`ifdef TTS_STOP_ON_FAIL_EN
    tbl[4] = '{"stopfail", 1, 16'h0010, 16'h0000,
               1'b0, 5'd1, 4'd4, 11};
`else
    tbl[4] = '{"onefail", 1, 16'h0010, 16'h0000,
               1'b0, 5'd1, 4'd4, 33};
`endif

    repeat (2) @(negedge clk);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_cap", 32'(captured), 0);
    chk("rst_mc", 32'(mismatch_count), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sweep(tbl[i].md, tbl[i].ex, 1'b0, cyc);
      chk({tbl[i].nm, "_cyc"}, 32'(cyc), 32'(tbl[i].cyc));
      chk({tbl[i].nm, "_cap"}, 32'(captured), 32'(tbl[i].cap));
      chk({tbl[i].nm, "_pass"}, 32'(pass), 32'(tbl[i].ps));
      chk({tbl[i].nm, "_mc"}, 32'(mismatch_count),
          32'(tbl[i].mc));
      chk({tbl[i].nm, "_fi"}, 32'(fail_index), 32'(tbl[i].fi));
      chk({tbl[i].nm, "_busy"}, 32'(busy), 0);
      @(negedge clk);
      chk({tbl[i].nm, "_pulse"}, 32'(done), 0);
    end

    // Reset mid-sweep at vec=5.
    @(negedge clk);
    mode = 0;
    expected = 16'hF900;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (vec != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach5", 32'(vec), 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_vec", 32'(vec), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cap", 32'(captured), 0);
    chk("mid_mc", 32'(mismatch_count), 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_nodone", 32'(dn), 0);
    sweep(0, 16'hF900, 1'b0, cyc);
    chk("mid_re_cyc", 32'(cyc), 33);
    chk("mid_re_pass", 32'(pass), 1);

    // Start pulse and mask change mid-sweep are ignored.
    @(negedge clk);
    mode = 0;
    expected = 16'hF900;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    expected = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    cyc = 6;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_cyc", 32'(cyc), 33);
    chk("ign_pass", 32'(pass), 1);
    chk("ign_cap", 32'(captured), 32'h0000F900);
    // start while in FINISH must not be accepted.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_fin_busy", 32'(busy), 0);
    @(negedge clk);
    chk("ign_fin_busy2", 32'(busy), 0);

    // start held high: done, one IDLE cycle, re-accept.
    sweep(0, 16'hF900, 1'b1, cyc);
    chk("held_cyc", 32'(cyc), 33);
    @(negedge clk);
    chk("held_idle", 32'(busy), 0);
    @(negedge clk);
    chk("held_acc", 32'(busy), 1);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_cyc2", 32'(cyc), 33);
    chk("held_pass2", 32'(pass), 1);

    // Minimum configuration, one vector per cycle.
    @(negedge clk);
    e3 = 8'hCD;
    s3 = 1'b1;
    @(posedge clk);
    #1 s3 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc <= 8) chk("min_vec", 32'(v3), 32'(cyc - 1));
    end while (!d3 && cyc < 100);
    chk("min_cyc", 32'(cyc), 9);
    chk("min_pass", 32'(p3), 1);
    chk("min_cap", 32'(c3), 32'hCD);
    chk("min_mc", 32'(mc3), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
